mpdmac_job_sched: RTL and testbench

- Two-requester job scheduler in front of the matrix-transpose DMA engine.
- Accepts transfer jobs (src, dst, matrix width, tag) from two requesters, round-robin arbitrates them into a job queue, and issues queued jobs to the engine one at a time through its src/dst/width/start/done interface.
- Returns a per-job completion record (tag, requester id, error flag) over a valid/ready channel.

---
 rtl/mpdmac_job_sched.sv | 178 +++++++++++++++++
 tb/tb_mpdmac_job_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpdmac_job_sched.sv
// rtl/mpdmac_job_sched.sv - two-requester round-robin job scheduler for the transpose DMA engine
//
// Purpose: accepts transfer jobs from two requesters, queues them in a small
// FIFO and issues them one at a time to the DMA engine. Each finished job
// produces a completion record.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   reqN_valid_i / reqN_ready_o     requester N job handshake (N = 0, 1)
//   reqN_src_i/dst_i/width_i/tag_i  requester N job fields
//   cmp_valid_o / cmp_ready_i       completion record handshake
//   cmp_tag_o, cmp_id_o, cmp_err_o  completion record fields
//   eng_src_addr_o, eng_dst_addr_o,
//   eng_mat_width_o, eng_start_o    engine command (start is a 1-cycle pulse)
//   eng_done_i                      engine idle flag (low while busy)
//   busy_o                          scheduler FSM is not idle
//   q_cnt_o                         job queue occupancy
module mpdmac_job_sched #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 4,
   parameter int ACK_TO = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req0_valid_i,
   output logic                       req0_ready_o,
   input  logic [31:0]                req0_src_i,
   input  logic [31:0]                req0_dst_i,
   input  logic [5:0]                 req0_width_i,
   input  logic [TAG_W-1:0]           req0_tag_i,
   input  logic                       req1_valid_i,
   output logic                       req1_ready_o,
   input  logic [31:0]                req1_src_i,
   input  logic [31:0]                req1_dst_i,
   input  logic [5:0]                 req1_width_i,
   input  logic [TAG_W-1:0]           req1_tag_i,
   output logic                       cmp_valid_o,
   input  logic                       cmp_ready_i,
   output logic [TAG_W-1:0]           cmp_tag_o,
   output logic                       cmp_id_o,
   output logic                       cmp_err_o,
   output logic [31:0]                eng_src_addr_o,
   output logic [31:0]                eng_dst_addr_o,
   output logic [5:0]                 eng_mat_width_o,
   output logic                       eng_start_o,
   input  logic                       eng_done_i,
   output logic                       busy_o,
   output logic [$clog2(DEPTH):0]     q_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(ACK_TO + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, REPORT
   } state_t;

   state_t state_q, state_d;

   // Job queue storage
   logic [31:0]      src_mem [DEPTH];
   logic [31:0]      dst_mem [DEPTH];
   logic [5:0]       wid_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic             id_mem  [DEPTH];

   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      q_cnt;
   logic             full, empty;
   logic             last_id;   // requester granted by the most recent accepted push
   logic             push, pop;

   logic [CW-1:0]    ack_cnt;
   logic             ack_timeout;

   assign full  = (q_cnt == (AW+1)'(DEPTH));
   assign empty = (q_cnt == '0);

   // Round-robin: on contention the requester not granted last wins.
   // last_id resets to 0, so requester 1 wins the first contended cycle.
   assign req0_ready_o = !full && req0_valid_i && (!req1_valid_i || last_id);
   assign req1_ready_o = !full && req1_valid_i && (!req0_valid_i || !last_id);
   assign push         = req0_ready_o || req1_ready_o;
   assign pop          = (state_q == LOAD);

   always_ff @(posedge clk) begin
      if (push) begin
         src_mem[wr_ptr] <= req1_ready_o ? req1_src_i   : req0_src_i;
         dst_mem[wr_ptr] <= req1_ready_o ? req1_dst_i   : req0_dst_i;
         wid_mem[wr_ptr] <= req1_ready_o ? req1_width_i : req0_width_i;
         tag_mem[wr_ptr] <= req1_ready_o ? req1_tag_i   : req0_tag_i;
         id_mem[wr_ptr]  <= req1_ready_o;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_cnt   <= '0;
         last_id <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            last_id <= req1_ready_o;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   q_cnt <= q_cnt + 1'b1;
            2'b01:   q_cnt <= q_cnt - 1'b1;
            default: q_cnt <= q_cnt;
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      ack_timeout = 1'b0;
      case (state_q)
         IDLE:      if (!empty) state_d = LOAD;
         LOAD:      state_d = (wid_mem[rd_ptr] == 6'd0) ? REPORT : ISSUE;
         ISSUE:     state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (!eng_done_i) begin
               state_d = WAIT_DONE;
            end else if (ack_cnt == CW'(ACK_TO - 1)) begin
               // The counter reaching ACK_TO-1 here means this is the
               // ACK_TO-th cycle spent waiting, so REPORT lands ACK_TO
               // cycles after WAIT_ACK entry.
               state_d     = REPORT;
               ack_timeout = 1'b1;
            end
         end
         WAIT_DONE: if (eng_done_i) state_d = REPORT;
         REPORT:    if (cmp_ready_i) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         ack_cnt         <= '0;
         eng_src_addr_o  <= '0;
         eng_dst_addr_o  <= '0;
         eng_mat_width_o <= '0;
         cmp_tag_o       <= '0;
         cmp_id_o        <= 1'b0;
         cmp_err_o       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ISSUE) begin
            ack_cnt <= '0;
         end else if (state_q == WAIT_ACK && eng_done_i && !ack_timeout) begin
            ack_cnt <= ack_cnt + 1'b1;
         end
         if (state_q == LOAD) begin
            eng_src_addr_o  <= src_mem[rd_ptr];
            eng_dst_addr_o  <= dst_mem[rd_ptr];
            eng_mat_width_o <= wid_mem[rd_ptr];
            cmp_tag_o       <= tag_mem[rd_ptr];
            cmp_id_o        <= id_mem[rd_ptr];
            cmp_err_o       <= (wid_mem[rd_ptr] == 6'd0);
         end else if (ack_timeout) begin
            cmp_err_o <= 1'b1;
         end
      end
   end

   assign eng_start_o = (state_q == ISSUE);
   assign cmp_valid_o = (state_q == REPORT);
   assign busy_o      = (state_q != IDLE);
   assign q_cnt_o     = q_cnt;

endmodule

// File: tb/tb_mpdmac_job_sched.sv
// tb/tb_mpdmac_job_sched.sv - directed self-checking bench for mpdmac_job_sched
module tb_mpdmac_job_sched;

   localparam int DEPTH  = 4;
   localparam int TAG_W  = 4;
   localparam int ACK_TO = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0]      req0_src, req0_dst, req1_src, req1_dst;
   logic [5:0]       req0_width, req1_width;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic             cmp_valid, cmp_ready, cmp_id, cmp_err;
   logic [TAG_W-1:0] cmp_tag;
   logic [31:0]      eng_src, eng_dst;
   logic [5:0]       eng_width;
   logic             eng_start, eng_done, busy;
   logic [2:0]       q_cnt;

   int errors = 0;
   int checks = 0;
   int eng_mode = 0;     // 0: normal engine, 1: never acknowledges
   int start_cnt = 0;
   int dn_cnt;
   bit saw_cmp = 1'b0;

   mpdmac_job_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ACK_TO(ACK_TO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
      .req0_src_i(req0_src), .req0_dst_i(req0_dst),
      .req0_width_i(req0_width), .req0_tag_i(req0_tag),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
      .req1_src_i(req1_src), .req1_dst_i(req1_dst),
      .req1_width_i(req1_width), .req1_tag_i(req1_tag),
      .cmp_valid_o(cmp_valid), .cmp_ready_i(cmp_ready),
      .cmp_tag_o(cmp_tag), .cmp_id_o(cmp_id), .cmp_err_o(cmp_err),
      .eng_src_addr_o(eng_src), .eng_dst_addr_o(eng_dst),
      .eng_mat_width_o(eng_width), .eng_start_o(eng_start),
      .eng_done_i(eng_done), .busy_o(busy), .q_cnt_o(q_cnt)
   );

   always #5 clk = ~clk;

   // Engine model: done drops the cycle after start and rises 20 cycles later
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_done <= 1'b1;
         dn_cnt   <= 0;
      end else if (eng_start && eng_mode == 0) begin
         eng_done <= 1'b0;
         dn_cnt   <= 20;
      end else if (dn_cnt > 0) begin
         dn_cnt <= dn_cnt - 1;
         if (dn_cnt == 1) eng_done <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (eng_start) start_cnt = start_cnt + 1;
      if (cmp_valid) saw_cmp = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0_valid = 0; req1_valid = 0;
      req0_src = 0; req0_dst = 0; req0_width = 0; req0_tag = 0;
      req1_src = 0; req1_dst = 0; req1_width = 0; req1_tag = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   // Single-requester push; queue must not be full
   task automatic push(input bit id, input logic [31:0] s, input logic [31:0] d,
                       input logic [5:0] w, input logic [TAG_W-1:0] t);
      if (id) begin
         req1_valid = 1; req1_src = s; req1_dst = d; req1_width = w; req1_tag = t;
      end else begin
         req0_valid = 1; req0_src = s; req0_dst = d; req0_width = w; req0_tag = t;
      end
      tick();
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic wait_cmp(input int max);
      int n = 0;
      while (!cmp_valid && n < max) begin
         tick();
         n++;
      end
      if (!cmp_valid) chk("cmp_wait", cmp_valid, 1);
   endtask

   logic [1:0] exp_gnt [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};

   initial begin
      int n, s0;
      bit stable;
      rst = 1'b1;
      cmp_ready = 1'b1;
      clear_inputs();
      repeat (2) tick();
      chk("rst_busy", busy, 0);
      chk("rst_qcnt", q_cnt, 0);
      chk("rst_cmp_valid", cmp_valid, 0);
      chk("rst_start", eng_start, 0);
      chk("rst_src", eng_src, 0);
      chk("rst_err", cmp_err, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Fairness: both requesters valid continuously
      req0_valid = 1; req0_width = 8; req0_tag = 4'h1;
      req1_valid = 1; req1_width = 8; req1_tag = 4'h2;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("fair_gnt%0d", i), {req1_ready, req0_ready}, exp_gnt[i]);
         tick();
      end
      chk("fair_full_cnt", q_cnt, 4);
      req0_valid = 0; req1_valid = 0;
      n = 0;
      while (q_cnt == 3'd4 && n < 100) begin
         tick();
         n++;
      end
      chk("fair_drain", q_cnt, 3);
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("fair_reassert", {req1_ready, req0_ready}, 2'b01);
      tick();
      do_reset();

      // Single job
      req0_valid = 1; req0_src = 32'h1000; req0_dst = 32'h2000; req0_width = 8; req0_tag = 3;
      #1;
      chk("single_ready", req0_ready, 1);
      tick();
      req0_valid = 0;
      chk("single_qcnt", q_cnt, 1);
      chk("single_idle", busy, 0);
      tick();
      chk("single_load_busy", busy, 1);
      chk("single_load_nostart", eng_start, 0);
      tick();
      chk("single_start", eng_start, 1);
      chk("single_src", eng_src, 32'h1000);
      chk("single_dst", eng_dst, 32'h2000);
      chk("single_width", eng_width, 8);
      wait_cmp(60);
      chk("single_tag", cmp_tag, 3);
      chk("single_id", cmp_id, 0);
      chk("single_err", cmp_err, 0);
      chk("single_src_hold", eng_src, 32'h1000);
      tick();
      chk("single_cmp_done", cmp_valid, 0);
      chk("single_back_idle", busy, 0);

      // Width zero, followed by a normal job
      s0 = start_cnt;
      push(0, 32'h10, 32'h20, 0, 5);
      push(1, 32'h3000, 32'h4000, 4, 6);
      wait_cmp(20);
      chk("wz_tag", cmp_tag, 5);
      chk("wz_err", cmp_err, 1);
      chk("wz_nostart", start_cnt, s0);
      tick();
      wait_cmp(60);
      chk("wz_next_tag", cmp_tag, 6);
      chk("wz_next_id", cmp_id, 1);
      chk("wz_next_err", cmp_err, 0);
      chk("wz_next_start", start_cnt, s0 + 1);
      tick();

      // Ack timeout on two queued jobs
      eng_mode = 1;
      push(0, 32'h50, 32'h60, 2, 7);
      push(0, 32'h70, 32'h80, 3, 8);
      n = 0;
      while (!eng_start && n < 10) begin
         tick();
         n++;
      end
      chk("to_start", eng_start, 1);
      n = 0;
      while (!cmp_valid && n < 40) begin
         tick();
         n++;
      end
      chk("to_latency", n, ACK_TO + 1);
      chk("to_tag", cmp_tag, 7);
      chk("to_err", cmp_err, 1);
      tick();
      wait_cmp(40);
      chk("to_next_tag", cmp_tag, 8);
      chk("to_next_err", cmp_err, 1);
      tick();
      eng_mode = 0;

      // Completion backpressure
      cmp_ready = 0;
      push(0, 32'h5000, 32'h6000, 5, 9);
      wait_cmp(60);
      s0 = start_cnt;
      req0_valid = 1; req0_width = 1; req0_tag = 10;
      req1_valid = 1; req1_width = 1; req1_tag = 11;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!cmp_valid || cmp_tag != 4'd9 || eng_src != 32'h5000) stable = 1'b0;
         tick();
      end
      chk("bp_stable", stable, 1);
      chk("bp_tag", cmp_tag, 9);
      chk("bp_full", q_cnt, 4);
      #1;
      chk("bp_ready", {req1_ready, req0_ready}, 2'b00);
      chk("bp_nostart", start_cnt, s0);
      cmp_ready = 1;
      do_reset();

      // Asynchronous reset during WAIT_DONE with three jobs queued
      for (int i = 0; i < 4; i++) push(0, 32'h100 * (i + 1), 32'h200, 4, 4'(i + 1));
      tick();
      chk("ar_qcnt", q_cnt, 3);
      chk("ar_busy", busy, 1);
      chk("ar_eng_busy", eng_done, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_busy0", busy, 0);
      chk("ar_qcnt0", q_cnt, 0);
      chk("ar_src0", eng_src, 0);
      chk("ar_start0", eng_start, 0);
      chk("ar_cmp0", cmp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      saw_cmp = 1'b0;
      repeat (40) tick();
      chk("ar_no_cmp", saw_cmp, 0);
      chk("ar_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule
